// File: rtl/miner_pkg.sv
// miner_pkg: shared FSM state type and record layout constants for the miner result write-back.
package miner_pkg;
    typedef enum logic [1:0] {IDLE, WR_BODY, WR_STATUS, DONE} state_t;
    localparam logic [7:0] STATUS_MAGIC = 8'hB1;
    localparam int         RECORD_WORDS = 10;
    localparam logic [3:0] STATUS_IDX   = 4'd0;
    localparam logic [3:0] NONCE_IDX    = 4'd1;
    localparam logic [3:0] HASH_IDX0    = 4'd2;
endpackage

// File: rtl/miner_result_master.sv
// miner_result_master: captures a mining result and writes a 10-word record to host memory over Avalon-MM,
// body words first and the status word last so a polling host never sees a partial record.
module miner_result_master
    import miner_pkg::*;
#(
    parameter int ADDRW      = 26,
    parameter int DATAW      = 32,
    parameter int HASH_WORDS = 8
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    result_valid,
    input  logic                    result_found,
    input  logic                    result_error,
    input  logic [31:0]             result_nonce,
    input  logic [32*HASH_WORDS-1:0] result_hash,
    input  logic [ADDRW-1:0]        base_addr,
    output logic                    busy,
    output logic                    done,
    output logic                    dropped,
    output logic [ADDRW-1:0]        master_address,
    output logic                    master_write,
    output logic [DATAW-1:0]        master_writedata,
    output logic [3:0]              master_byteenable,
    input  logic                    master_waitrequest
);
    localparam logic [3:0] LAST_IDX = 4'(RECORD_WORDS - 1);

    state_t                  state_q, state_d;
    logic [3:0]              idx_q, idx_d;
    logic [7:0]              seq_q, seq_d;
    logic [31:0]             nonce_q;
    logic [32*HASH_WORDS-1:0] hash_q;
    logic                    found_q, error_q, dropped_q, cap;
    logic [ADDRW-1:0]        base_q;
    logic [DATAW-1:0]        word;
    logic                    wr;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            idx_q     <= STATUS_IDX;
            seq_q     <= '0;
            nonce_q   <= '0;
            hash_q    <= '0;
            found_q   <= 1'b0;
            error_q   <= 1'b0;
            base_q    <= '0;
            dropped_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            seq_q     <= seq_d;
            dropped_q <= result_valid && state_q != IDLE;
            if (cap) begin
                nonce_q <= result_nonce;
                hash_q  <= result_hash;
                found_q <= result_found;
                error_q <= result_error;
                base_q  <= base_addr;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        seq_d   = seq_q;
        cap     = 1'b0;
        case (state_q)
            IDLE: if (result_valid) begin
                cap     = 1'b1;
                idx_d   = NONCE_IDX;
                state_d = WR_BODY;
            end
            WR_BODY: if (!master_waitrequest) begin
                idx_d   = idx_q == LAST_IDX ? STATUS_IDX : idx_q + 4'd1;
                state_d = idx_q == LAST_IDX ? WR_STATUS : WR_BODY;
            end
            WR_STATUS: if (!master_waitrequest) begin
                seq_d   = seq_q + 8'd1;
                state_d = DONE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Word select: hash words are stored most-significant first in the record
    always_comb begin
        word = '0;
        case (idx_q)
            STATUS_IDX: word = {STATUS_MAGIC, seq_q, 14'b0, error_q, found_q};
            NONCE_IDX:  word = nonce_q;
            default:
                for (int k = 0; k < HASH_WORDS; k++)
                    if (idx_q == 4'(int'(HASH_IDX0) + k)) word = hash_q[32*(HASH_WORDS-1-k) +: 32];
        endcase
    end

    assign wr                = state_q == WR_BODY || state_q == WR_STATUS;
    assign master_write      = wr;
    assign master_address    = wr ? (base_q & ~ADDRW'(3)) + ADDRW'({idx_q, 2'b00}) : '0;
    assign master_writedata  = wr ? word : '0;
    assign master_byteenable = wr ? 4'hF : 4'h0;
    assign busy              = state_q != IDLE;
    assign done              = state_q == DONE;
    assign dropped           = dropped_q;
endmodule

// File: tb/tb_miner_result_master.sv
// tb_miner_result_master: directed checks of record contents, ordering, stalls, drops, wrap and reset.
module tb_miner_result_master;
    logic         clk, rst;
    logic         result_valid, result_found, result_error;
    logic [31:0]  result_nonce;
    logic [255:0] result_hash;
    logic [25:0]  base_addr;
    logic         busy, done, dropped;
    logic [25:0]  master_address;
    logic         master_write;
    logic [31:0]  master_writedata;
    logic [3:0]   master_byteenable;
    logic         master_waitrequest;

    miner_result_master dut (
        .clk(clk), .rst(rst),
        .result_valid(result_valid), .result_found(result_found), .result_error(result_error),
        .result_nonce(result_nonce), .result_hash(result_hash), .base_addr(base_addr),
        .busy(busy), .done(done), .dropped(dropped),
        .master_address(master_address), .master_write(master_write),
        .master_writedata(master_writedata), .master_byteenable(master_byteenable),
        .master_waitrequest(master_waitrequest)
    );

    initial clk = 0;
    always #5 clk = ~clk;

    int ntest = 0, nfail = 0;
    int cyc = 0, c0 = 0;
    int nw = 0, done_cyc = -1, drop_cyc = -1, stall_bad = 0, be_bad = 0;
    logic [25:0] wa [0:255];
    logic [31:0] wd [0:255];
    logic        prev_stall = 0;
    logic [25:0] pa;
    logic [31:0] pd;

    always @(posedge clk) cyc <= cyc + 1;

    // Accepted writes, done/dropped timing and stall stability, observed mid-cycle
    always @(negedge clk) begin
        if (master_write && !master_waitrequest && nw < 256) begin
            wa[nw] <= master_address;
            wd[nw] <= master_writedata;
            nw     <= nw + 1;
        end
        if (done) done_cyc <= cyc;
        if (dropped) drop_cyc <= cyc;
        if (master_write && master_byteenable != 4'hF) be_bad <= be_bad + 1;
        if (prev_stall && (!master_write || master_address != pa || master_writedata != pd))
            stall_bad <= stall_bad + 1;
        prev_stall <= master_write && master_waitrequest;
        pa <= master_address;
        pd <= master_writedata;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        ntest++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic start(input logic [25:0] b, input logic [31:0] n, input logic [255:0] h,
                         input logic f, input logic e);
        base_addr = b; result_nonce = n; result_hash = h;
        result_found = f; result_error = e;
        result_valid = 1; master_waitrequest = 0;
        c0 = cyc;
    endtask

    // Advance n cycles; waitrequest follows mask bit k in cycle k; inputs are scrambled after capture
    task automatic run(input int n, input logic [31:0] mask, input int drop_at);
        for (int k = 1; k <= n; k++) begin
            tick();
            result_valid = (k == drop_at);
            master_waitrequest = mask[k];
            result_nonce = ~result_nonce;
            result_hash = ~result_hash;
            result_found = ~result_found;
            base_addr = base_addr + 26'h40;
        end
    endtask

    task automatic chk_rec(input string nm, input int s, input logic [25:0] b, input logic [31:0] n,
                           input logic [255:0] h, input logic [7:0] sq, input logic f, input logic e);
        for (int j = 0; j < 10; j++) begin
            int i;
            logic [25:0] ea;
            logic [31:0] ed;
            i  = (j == 9) ? 0 : j + 1;
            ea = (b & ~26'h3) + 26'(4 * i);
            ed = (i == 0) ? {8'hB1, sq, 14'b0, e, f} : (i == 1) ? n : h[255 - 32*(i-2) -: 32];
            chk($sformatf("%s_w%0d_addr", nm, i), 64'(wa[s+j]), 64'(ea));
            chk($sformatf("%s_w%0d_data", nm, i), 64'(wd[s+j]), 64'(ed));
        end
    endtask

    task automatic do_reset();
        rst = 1;
        tick();
        tick();
        rst = 0;
    endtask

    logic [255:0] ha, hb;
    int s;

    initial begin
        for (int k = 0; k < 8; k++) ha[255 - 32*k -: 32] = 32'h1111_1111 * (k + 1);
        hb = ~ha;
        rst = 1; result_valid = 0; result_found = 0; result_error = 0;
        result_nonce = 0; result_hash = 0; base_addr = 0; master_waitrequest = 0;
        tick();
        tick();
        chk("rst_busy", 64'(busy), 64'(0));
        chk("rst_done", 64'(done), 64'(0));
        chk("rst_dropped", 64'(dropped), 64'(0));
        chk("rst_write", 64'(master_write), 64'(0));
        chk("rst_addr", 64'(master_address), 64'(0));
        chk("rst_data", 64'(master_writedata), 64'(0));
        chk("rst_be", 64'(master_byteenable), 64'(0));
        rst = 0;
        tick();

        // A: no stalls
        s = nw;
        start(26'h0000100, 32'hDEADBEEF, ha, 1, 0);
        run(12, 32'h0, -1);
        chk("A_count", 64'(nw - s), 64'(10));
        chk("A_first_addr", 64'(wa[s]), 64'h104);
        chk("A_first_data", 64'(wd[s]), 64'hDEADBEEF);
        chk("A_hash7_data", 64'(wd[s+8]), 64'h88888888);
        chk("A_status_addr", 64'(wa[s+9]), 64'h100);
        chk("A_status_data", 64'(wd[s+9]), 64'hB1000001);
        chk_rec("A", s, 26'h0000100, 32'hDEADBEEF, ha, 8'd0, 1, 0);
        chk("A_done_cyc", 64'(done_cyc - c0), 64'(11));
        chk("A_busy_after", 64'(busy), 64'(0));
        chk("A_be", 64'(be_bad), 64'(0));

        // B: 3 stalls on word 2, 2 stalls on status
        s = nw;
        start(26'h0000100, 32'hDEADBEEF, ha, 1, 0);
        run(17, 32'h0000_601C, -1);
        chk("B_count", 64'(nw - s), 64'(10));
        chk_rec("B", s, 26'h0000100, 32'hDEADBEEF, ha, 8'd1, 1, 0);
        chk("B_done_cyc", 64'(done_cyc - c0), 64'(16));
        chk("B_stable", 64'(stall_bad), 64'(0));

        // C/D: back-to-back after reset, seq 0 then 1
        do_reset();
        s = nw;
        start(26'h0000200, 32'h0000_0042, ha, 1, 0);
        run(12, 32'h0, -1);
        chk("C_status", 64'(wd[s+9]), 64'hB1000001);
        chk_rec("C", s, 26'h0000200, 32'h0000_0042, ha, 8'd0, 1, 0);
        s = nw;
        start(26'h0000203, 32'h1234_5678, hb, 1, 0);
        run(12, 32'h0, -1);
        chk("D_status", 64'(wd[s+9]), 64'hB1010001);
        chk("D_status_addr", 64'(wa[s+9]), 64'h200);
        chk_rec("D", s, 26'h0000200, 32'h1234_5678, hb, 8'd1, 1, 0);

        // E: result_valid in cycle 5 of an active record is dropped
        s = nw;
        start(26'h0000300, 32'hCAFE_F00D, ha, 1, 1);
        run(12, 32'h0, 5);
        chk("E_drop_cyc", 64'(drop_cyc - c0), 64'(6));
        chk("E_count", 64'(nw - s), 64'(10));
        chk("E_status", 64'(wd[s+9]), 64'hB1020003);
        chk_rec("E", s, 26'h0000300, 32'hCAFE_F00D, ha, 8'd2, 1, 1);

        // F: address wrap past 2^26
        do_reset();
        s = nw;
        start(26'h3FFFFFC, 32'hA5A5_5A5A, ha, 0, 1);
        run(12, 32'h0, -1);
        chk("F_nonce_addr", 64'(wa[s]), 64'h0);
        chk("F_last_hash_addr", 64'(wa[s+8]), 64'h20);
        chk("F_status_addr", 64'(wa[s+9]), 64'h3FFFFFC);
        chk("F_status", 64'(wd[s+9]), 64'hB1000002);
        chk_rec("F", s, 26'h3FFFFFC, 32'hA5A5_5A5A, ha, 8'd0, 0, 1);

        // G/H: reset while stalled in WR_BODY, then a fresh record restarts seq at 0
        start(26'h0000400, 32'h0BAD_0BAD, ha, 1, 0);
        run(3, 32'hFFFF_FFFF, -1);
        chk("G_write_stalled", 64'(master_write), 64'(1));
        rst = 1;
        tick();
        chk("G_write_after_rst", 64'(master_write), 64'(0));
        chk("G_busy_after_rst", 64'(busy), 64'(0));
        rst = 0;
        s = nw;
        start(26'h0000500, 32'h7777_0001, hb, 1, 0);
        run(12, 32'h0, -1);
        chk("H_count", 64'(nw - s), 64'(10));
        chk("H_status", 64'(wd[s+9]), 64'hB1000001);
        chk_rec("H", s, 26'h0000500, 32'h7777_0001, hb, 8'd0, 1, 0);

        $display("[TB] %0d tests run, %0d failed", ntest, nfail);
        $finish;
    end
endmodule
